directory_bus_arbiter: RTL and testbench
========================================

// Module: directory_bus_arbiter
// PURPOSE
//   Shares one directory controller among NREQ cache controllers. Picks one pending
//   miss or write-back per transaction using round-robin order, forwards its 3-bit bus
//   code to the directory, waits for the directory reply, and routes the reply back to
//   the winner. A watchdog aborts transactions the directory never answers.
//   Sits between the per-processor cache FSMs and the directory FSM.
// PARAMETERS
//   NREQ     4   number of requesters (2..2**IDW)
//   IDW      2   width of requester index
//   TIMEOUT  15  WAIT-state cycles without dir_done before abort (>=1)
// PORTS
//   clock        in   1        rising-edge clock
//   reset        in   1        asynchronous, active-low reset
//   req          in   NREQ     request line per requester, held until rsp_valid
//   req_bus      in   3*NREQ   bus code of requester i at [3*i+2:3*i] (1 read miss, 2 write miss, 3 data write-back)
//   gnt          out  NREQ     one-hot grant, high from ISSUE through RESP
//   dir_valid    out  1        one-cycle strobe: dir_bus/dir_src valid
//   dir_bus      out  3        latched bus code of winner
//   dir_src      out  IDW      index of winner
//   dir_done     in   1        directory reply strobe
//   dir_signal   in   3        directory reply code, sampled with dir_done
//   rsp_valid    out  1        one-cycle reply strobe to winner
//   rsp_signal   out  3        reply code (7 = abort on timeout)
//   rsp_dst      out  IDW      index of reply target
//   timeout_err  out  1        sticky, set on any abort
//   state_out    out  3        current FSM state, for 7-segment debug
// BEHAVIOUR
//   Reset (reset=0, async): state IDLE, rr pointer 0, all outputs 0, counter 0. Any
//     in-flight transaction is dropped; no rsp_valid is issued for it.
//   Eligible requester: req[i]=1 and code in 1..3. Codes 0 and 4..7 are ignored.
//   States (state_out): IDLE=0, ISSUE=1, WAIT=2, RESP=3.
//   IDLE: if any eligible requester exists, pick the first eligible index scanning up
//     from ptr (mod NREQ). Latch index and code. Set gnt=onehot(index). Go to ISSUE.
//     Otherwise stay.
//   ISSUE: dir_valid=1, dir_bus=code, dir_src=index for exactly one cycle. Clear counter.
//     Go to WAIT.
//   WAIT: if dir_done, latch dir_signal and go to RESP. Otherwise, increment counter. If the
//     counter reaches TIMEOUT, latch rsp_signal=7, set timeout_err, and go to RESP.
//     dir_done in the same cycle the counter would expire: dir_done wins (normal reply).
//   RESP: rsp_valid=1 and rsp_dst=index for one cycle. At next edge: gnt=0, ptr=(index+1)
//     mod NREQ, go to IDLE.
//   dir_done outside WAIT is ignored. Deasserting req mid-transaction does not abort.
//   Changing req_bus after ISSUE has no effect.
//   All outputs are registered. dir_valid/rsp_valid are never high twice per transaction.
//   Minimum latency: eligible req seen in IDLE cycle N -> dir_valid cycle N+1 -> dir_done
//     in cycle N+2 -> rsp_valid cycle N+3. Back-to-back transactions are separated by one IDLE cycle.
//   timeout_err clears only on reset.
// TESTING
//   1 req=0001, code 1, dir_done with dir_signal=4 in first WAIT cycle -> gnt=0001;
//     dir_valid 1 cycle with dir_bus=1, dir_src=0; rsp_valid 3 cycles after req sampled,
//     rsp_signal=4, rsp_dst=0.
//   2 req=1111, all code 2 held, dir_done each first WAIT cycle -> grants in order
//     0,1,2,3,0; each gnt one-hot; one IDLE cycle between transactions.
//   3 req=0010 with code 0, then code 5 -> no gnt, no dir_valid, state_out stays 0.
//   4 TIMEOUT=15, no dir_done -> 15 WAIT cycles, then rsp_valid with rsp_signal=7 and
//     timeout_err=1. timeout_err stays 1 through later normal transactions.
//   5 dir_done with dir_signal=2 on the 15th WAIT cycle -> rsp_signal=2, timeout_err=0.
//   6 reset=0 during WAIT with requester 2 granted -> all outputs 0 immediately, no
//     rsp_valid. After release, req=1111 -> first grant goes to requester 0.

Source files
------------

// File: rtl/directory_bus_arbiter_if.sv
// rtl/directory_bus_arbiter_if.sv - requester/directory bus bundle for the directory bus arbiter
interface directory_bus_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);

  // requester side
  logic [NREQ-1:0]   req;
  logic [3*NREQ-1:0] req_bus;
  logic [NREQ-1:0]   gnt;

  // directory side
  logic              dir_valid;
  logic [2:0]        dir_bus;
  logic [IDW-1:0]    dir_src;
  logic              dir_done;
  logic [2:0]        dir_signal;

  // reply routing and debug
  logic              rsp_valid;
  logic [2:0]        rsp_signal;
  logic [IDW-1:0]    rsp_dst;
  logic              timeout_err;
  logic [2:0]        state_out;

  // arbiter view
  modport slave (
    input  req, req_bus, dir_done, dir_signal,
    output gnt, dir_valid, dir_bus, dir_src,
           rsp_valid, rsp_signal, rsp_dst, timeout_err, state_out
  );

  // view of the cache controllers and directory that surround the arbiter
  modport master (
    output req, req_bus, dir_done, dir_signal,
    input  gnt, dir_valid, dir_bus, dir_src,
           rsp_valid, rsp_signal, rsp_dst, timeout_err, state_out
  );

endinterface

// File: rtl/directory_bus_arbiter.sv
// rtl/directory_bus_arbiter.sv - round-robin arbiter sharing one directory among NREQ cache controllers
module directory_bus_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                        clock,
  input  logic                        reset,
  directory_bus_arbiter_if.slave      bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3
  } state_t;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  win;
  logic [CW-1:0]   cnt;

  logic [2:0]      codes [NREQ];
  logic [NREQ-1:0] elig;

  logic            pick_found;
  logic [IDW-1:0]  pick_idx;
  logic [2:0]      pick_code;
  logic [IDW-1:0]  scan_idx;
  logic [IDW-1:0]  next_ptr;

  // Unpack the per-requester bus codes; only read miss, write miss and write-back compete.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign codes[g] = bus.req_bus[3*g +: 3];
    assign elig[g]  = bus.req[g] && (codes[g] != 3'd0) && (codes[g] <= 3'd3);
  end

  // Round-robin scan from ptr; walking offsets high-to-low lets the nearest eligible slot win.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_code  = '0;
    scan_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_idx = IDW'((int'(ptr) + k) % NREQ);
      if (elig[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
        pick_code  = codes[scan_idx];
      end
    end
  end

  // Pointer moves just past the winner so it gets lowest priority next round.
  always_comb begin
    next_ptr = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
  end

  assign bus.state_out = state;

  // Transaction FSM: pick, issue to directory, wait for reply or watchdog, route reply.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      ptr             <= '0;
      win             <= '0;
      cnt             <= '0;
      bus.gnt         <= '0;
      bus.dir_valid   <= 1'b0;
      bus.dir_bus     <= '0;
      bus.dir_src     <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_signal  <= '0;
      bus.rsp_dst     <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.dir_valid <= 1'b0;
      bus.rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            win           <= pick_idx;
            bus.gnt       <= NREQ'(1) << pick_idx;
            bus.dir_valid <= 1'b1;
            bus.dir_bus   <= pick_code;
            bus.dir_src   <= pick_idx;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A reply arriving on the expiring cycle still counts as a normal reply.
          if (bus.dir_done) begin
            bus.rsp_valid  <= 1'b1;
            bus.rsp_signal <= bus.dir_signal;
            bus.rsp_dst    <= win;
            state          <= S_RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            bus.rsp_valid   <= 1'b1;
            bus.rsp_signal  <= 3'd7;
            bus.rsp_dst     <= win;
            bus.timeout_err <= 1'b1;
            state           <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          bus.gnt <= '0;
          ptr     <= next_ptr;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_directory_bus_arbiter.sv
// tb/tb_directory_bus_arbiter.sv - randomized and directed checks of directory_bus_arbiter against a transaction model
module tb_directory_bus_arbiter;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 15;

  logic clock;
  logic reset;

  directory_bus_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  directory_bus_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- transaction-level reference model ----------------
  // Each transaction is described by the edge on which it was picked (m_t0) and
  // the edge on which its reply was decided (m_resp_at); outputs follow from the
  // distance of the current edge to those stamps.
  int m_cyc = 0;
  bit m_busy = 0;
  bit m_replied = 0;
  int m_t0 = 0;
  int m_resp_at = 0;
  int m_win = 0;
  int m_code = 0;
  int m_reply = 0;
  int m_ptr = 0;
  bit m_terr = 0;
  int m_i;
  int m_c;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_busy = 0; m_replied = 0; m_ptr = 0; m_terr = 0; m_cyc = 0;
    end else begin
      m_cyc++;
      if (m_busy) begin
        if (m_replied && m_cyc == m_resp_at + 1) begin
          m_busy = 0; m_replied = 0; m_ptr = (m_win + 1) % NREQ;
        end else if (!m_replied && m_cyc - m_t0 >= 2) begin
          if (bus.dir_done) begin
            m_reply = int'(bus.dir_signal); m_replied = 1; m_resp_at = m_cyc;
          end else if (m_cyc - m_t0 - 1 == TIMEOUT) begin
            m_reply = 7; m_terr = 1; m_replied = 1; m_resp_at = m_cyc;
          end
        end
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          m_i = (m_ptr + k) % NREQ;
          m_c = int'(bus.req_bus[3*m_i +: 3]);
          if (!m_busy && bus.req[m_i] && m_c >= 1 && m_c <= 3) begin
            m_busy = 1; m_win = m_i; m_code = m_c; m_t0 = m_cyc;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    logic [31:0] e_gnt;
    bit e_dv, e_rv;
    int e_state;
    e_gnt   = m_busy ? (32'd1 << m_win) : 32'd0;
    e_dv    = m_busy && (m_cyc == m_t0);
    e_rv    = m_busy && m_replied && (m_cyc == m_resp_at);
    e_state = !m_busy ? 0 : e_dv ? 1 : e_rv ? 3 : 2;
    chk("gnt", bus.gnt, e_gnt);
    chk("dir_valid", bus.dir_valid, e_dv);
    chk("rsp_valid", bus.rsp_valid, e_rv);
    chk("state_out", bus.state_out, e_state);
    chk("timeout_err", bus.timeout_err, m_terr);
    if (e_dv) begin
      chk("dir_bus", bus.dir_bus, m_code);
      chk("dir_src", bus.dir_src, m_win);
    end
    if (e_rv) begin
      chk("rsp_signal", bus.rsp_signal, m_reply);
      chk("rsp_dst", bus.rsp_dst, m_win);
    end
  end

  // ---------------- stimulus ----------------
  bit         rand_mode = 0;
  int         done_pct  = 0;
  int         done_at   = 0;
  logic [2:0] rsp_code  = 3'd0;
  int         wcnt      = 0;

  // Advance one cycle, then act as the directory (reply on WAIT cycle done_at) or as random traffic.
  task automatic tick();
    @(posedge clock);
    #1;
    if (bus.state_out == 3'd2) wcnt++;
    else wcnt = 0;
    if (rand_mode) begin
      bus.req        = NREQ'($urandom);
      bus.req_bus    = (3*NREQ)'($urandom);
      bus.dir_done   = ($urandom_range(99) < done_pct);
      bus.dir_signal = 3'($urandom);
    end else begin
      bus.dir_done   = (wcnt != 0 && wcnt == done_at);
      bus.dir_signal = rsp_code;
    end
  endtask

  task automatic apply_reset();
    reset        = 1'b0;
    bus.req      = '0;
    bus.dir_done = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    wcnt  = 0;
  endtask

  int exp_order [5] = '{0, 1, 2, 3, 0};
  int srcs[$];
  int starts[$];
  int waits;
  bit seen;

  initial begin
    reset          = 1'b1;
    bus.req        = '0;
    bus.req_bus    = '0;
    bus.dir_done   = 1'b0;
    bus.dir_signal = '0;
    #2 reset = 1'b0;
    tick();
    tick();
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_dir_valid", bus.dir_valid, 0);
    chk("rst_dir_bus", bus.dir_bus, 0);
    chk("rst_dir_src", bus.dir_src, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_signal", bus.rsp_signal, 0);
    chk("rst_rsp_dst", bus.rsp_dst, 0);
    chk("rst_timeout_err", bus.timeout_err, 0);
    chk("rst_state", bus.state_out, 0);
    reset = 1'b1;

    // 1: single read miss, reply 4 in the first WAIT cycle
    done_at = 1; rsp_code = 3'd4;
    bus.req = 4'b0001; bus.req_bus = 12'h001;
    tick();
    chk("t1_gnt", bus.gnt, 4'b0001);
    chk("t1_dir_valid", bus.dir_valid, 1);
    chk("t1_dir_bus", bus.dir_bus, 1);
    chk("t1_dir_src", bus.dir_src, 0);
    tick();
    chk("t1_dir_valid_once", bus.dir_valid, 0);
    tick();
    chk("t1_rsp_valid", bus.rsp_valid, 1);
    chk("t1_rsp_signal", bus.rsp_signal, 4);
    chk("t1_rsp_dst", bus.rsp_dst, 0);
    bus.req = '0;
    tick();
    chk("t1_gnt_clear", bus.gnt, 0);
    chk("t1_rsp_valid_once", bus.rsp_valid, 0);

    // 2: all four contend with write misses; round-robin order, one IDLE between
    apply_reset();
    bus.req = 4'b1111; bus.req_bus = {4{3'd2}}; done_at = 1;
    srcs.delete(); starts.delete();
    for (int c = 0; c < 60 && srcs.size() < 5; c++) begin
      tick();
      chk("t2_onehot0", $onehot0(bus.gnt), 1);
      if (bus.dir_valid) begin
        srcs.push_back(int'(bus.dir_src));
        starts.push_back(c);
      end
    end
    chk("t2_count", srcs.size(), 5);
    for (int i = 0; i < srcs.size(); i++) chk("t2_order", srcs[i], exp_order[i]);
    for (int i = 1; i < starts.size(); i++) chk("t2_spacing", starts[i] - starts[i-1], 4);
    bus.req = '0;
    tick(); tick(); tick(); tick();

    // 3: ignored codes 0 and 5
    apply_reset();
    bus.req = 4'b0010; bus.req_bus = 12'h000;
    for (int c = 0; c < 16; c++) begin
      if (c == 8) bus.req_bus = 12'h028;
      tick();
      chk("t3_state", bus.state_out, 0);
      chk("t3_gnt", bus.gnt, 0);
      chk("t3_dir_valid", bus.dir_valid, 0);
    end

    // 4: directory never answers -> abort after TIMEOUT WAIT cycles
    apply_reset();
    bus.req = 4'b0001; bus.req_bus = 12'h003; done_at = 0;
    waits = 0; seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      if (bus.state_out == 3'd2) waits++;
      if (bus.rsp_valid) seen = 1;
    end
    chk("t4_seen", seen, 1);
    chk("t4_waits", waits, 15);
    chk("t4_rsp_signal", bus.rsp_signal, 7);
    chk("t4_timeout_err", bus.timeout_err, 1);
    done_at = 1; rsp_code = 3'd5; seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (bus.rsp_valid) seen = 1;
    end
    chk("t4_next_seen", seen, 1);
    chk("t4_next_rsp_signal", bus.rsp_signal, 5);
    chk("t4_err_sticky", bus.timeout_err, 1);
    bus.req = '0;
    tick(); tick();

    // 5: reply on the last WAIT cycle wins over the watchdog
    apply_reset();
    bus.req = 4'b0001; bus.req_bus = 12'h001; done_at = 15; rsp_code = 3'd2;
    waits = 0; seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      if (bus.state_out == 3'd2) waits++;
      if (bus.rsp_valid) seen = 1;
    end
    chk("t5_seen", seen, 1);
    chk("t5_waits", waits, 15);
    chk("t5_rsp_signal", bus.rsp_signal, 2);
    chk("t5_timeout_err", bus.timeout_err, 0);
    bus.req = '0;
    tick(); tick();

    // 6: async reset during WAIT drops the transaction
    apply_reset();
    bus.req = 4'b0100; bus.req_bus = 12'h040; done_at = 0;
    for (int c = 0; c < 10 && bus.state_out != 3'd2; c++) tick();
    chk("t6_wait", bus.state_out, 2);
    chk("t6_gnt", bus.gnt, 4'b0100);
    #1 reset = 1'b0;
    #1;
    chk("t6_gnt0", bus.gnt, 0);
    chk("t6_state0", bus.state_out, 0);
    chk("t6_dv0", bus.dir_valid, 0);
    chk("t6_rv0", bus.rsp_valid, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t6_no_rsp", bus.rsp_valid, 0);
    end
    reset = 1'b1;
    bus.req = 4'b1111; bus.req_bus = {4{3'd1}}; done_at = 1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (bus.dir_valid) seen = 1;
    end
    chk("t6_regrant", seen, 1);
    chk("t6_first_src", bus.dir_src, 0);
    chk("t6_first_gnt", bus.gnt, 4'b0001);

    // random traffic with prompt and sluggish directory, with occasional resets
    apply_reset();
    rand_mode = 1;
    for (int phase = 0; phase < 4; phase++) begin
      done_pct = (phase % 2 == 0) ? 30 : 3;
      for (int c = 0; c < 900; c++) tick();
      apply_reset();
    end
    rand_mode = 0;
    bus.req = '0;
    bus.dir_done = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
